// File: rtl/dcache_tag_flush_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dcache_tag_flush_walker
//  Purpose  : Reader-side companion of the dcache tag FIFO. A flush request
//             starts a walk over tag locations 0..DP-1. Each valid+dirty line
//             gets a writeback request. Once the writeback is acknowledged,
//             the line is rewritten through the tag update port. When the walk
//             completes, a done pulse (and optionally a tag FIFO flush pulse)
//             is emitted.
//  Build    : macro DCACHE_FLUSH_INVAL_EN
//             - defined  : updated lines are invalidated (written to zero),
//                          clean valid lines also get an update cycle, and
//                          tag_flush pulses together with flush_done.
//             - undefined: dirty lines are written back as valid+clean, clean
//                          lines are left alone, and tag_flush stays low.
//  Ports    : clk, reset_n       clock, asynchronous active-low reset
//             flush_req          start a walk (level, sampled only when idle)
//             tag_empty          tag FIFO empty; a walk then goes straight to done
//             tag_rptr/tag_rdata combinational tag read port
//             tag_uwr/uptr/udata single-cycle tag update write port
//             tag_flush          1-cycle tag FIFO flush pulse
//             wb_req/tag/index   writeback request; tag/index stable while req
//             wb_ack             writeback completion
//             flush_busy         high from accept until the done cycle ends
//             flush_done         1-cycle completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module dcache_tag_flush_walker #(
    parameter int WD = 8,
    parameter int DP = 4,
    localparam int AW = (DP > 1) ? $clog2(DP) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_req,
    input  logic          tag_empty,
    output logic [AW-1:0] tag_rptr,
    input  logic [WD-1:0] tag_rdata,
    output logic          tag_uwr,
    output logic [AW-1:0] tag_uptr,
    output logic [WD-1:0] tag_udata,
    output logic          tag_flush,
    output logic          wb_req,
    output logic [WD-3:0] wb_tag,
    output logic [AW-1:0] wb_index,
    input  logic          wb_ack,
    output logic          flush_busy,
    output logic          flush_done
);

`ifdef DCACHE_FLUSH_INVAL_EN
    localparam logic INVAL_EN = 1'b1;
`else
    localparam logic INVAL_EN = 1'b0;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(DP - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_WB   = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic [WD-3:0]   wb_tag_q, wb_tag_d;
    logic [AW-1:0]   wb_index_q, wb_index_d;

    logic            entry_valid;
    logic            entry_dirty;
    logic            idx_last;
    logic            advance;

    assign entry_valid = tag_rdata[WD-1];
    assign entry_dirty = tag_rdata[WD-2];
    assign idx_last    = (idx_q == LAST_IDX);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            wb_tag_q   <= '0;
            wb_index_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            wb_tag_q   <= wb_tag_d;
            wb_index_q <= wb_index_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        wb_tag_d   = wb_tag_q;
        wb_index_d = wb_index_q;
        advance    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = tag_empty ? S_DONE : S_SCAN;
                end
            end

            S_SCAN: begin
                if (entry_valid && entry_dirty) begin
                    wb_tag_d   = tag_rdata[WD-3:0];
                    wb_index_d = idx_q;
                    state_d    = S_WB;
                end else if (entry_valid && INVAL_EN) begin
                    state_d = S_UPD;
                end else begin
                    advance = 1'b1;
                end
            end

            S_WB: begin
                if (wb_ack) begin
                    state_d = S_UPD;
                end
            end

            S_UPD: begin
                advance = 1'b1;
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Moving to the next entry costs no extra cycle: it is folded into the
        // transition out of SCAN or UPD. The walk ends on the last index, so
        // idx never wraps.
        if (advance) begin
            if (idx_last) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_SCAN;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tag_rptr   = idx_q;
    assign tag_uwr    = (state_q == S_UPD);
    assign tag_uptr   = tag_uwr ? idx_q : '0;
    assign wb_req     = (state_q == S_WB);
    assign wb_tag     = wb_tag_q;
    assign wb_index   = wb_index_q;
    assign flush_busy = busy_q;
    assign flush_done = (state_q == S_DONE);

`ifdef DCACHE_FLUSH_INVAL_EN
    assign tag_udata  = '0;
    assign tag_flush  = flush_done;
`else
    // Only dirty lines reach UPD in this build, so the latched writeback tag
    // is the tag of the line being cleaned.
    assign tag_udata  = tag_uwr ? {1'b1, 1'b0, wb_tag_q} : '0;
    assign tag_flush  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_tag_flush_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_tag_flush_walker
//  Purpose  : Self-checking bench for dcache_tag_flush_walker. A behavioural
//             tag memory feeds the read port and absorbs updates; each walk is
//             predicted from the memory contents (writeback list, update list,
//             cycle count, final memory) and compared against observation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_tag_flush_walker;

    localparam int WD = 8;
    localparam int DP = 4;
    localparam int AW = 2;
`ifdef DCACHE_FLUSH_INVAL_EN
    localparam bit INVAL = 1'b1;
`else
    localparam bit INVAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush_req = 1'b0;
    logic          tag_empty = 1'b0;
    logic          wb_ack = 1'b0;
    logic [AW-1:0] tag_rptr, tag_uptr, wb_index;
    logic [WD-1:0] tag_rdata, tag_udata;
    logic [WD-3:0] wb_tag;
    logic          tag_uwr, tag_flush, wb_req, flush_busy, flush_done;

    logic [WD-1:0] mem [DP];
    assign tag_rdata = mem[tag_rptr];

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    dcache_tag_flush_walker #(.WD(WD), .DP(DP)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_req  (flush_req),
        .tag_empty  (tag_empty),
        .tag_rptr   (tag_rptr),
        .tag_rdata  (tag_rdata),
        .tag_uwr    (tag_uwr),
        .tag_uptr   (tag_uptr),
        .tag_udata  (tag_udata),
        .tag_flush  (tag_flush),
        .wb_req     (wb_req),
        .wb_tag     (wb_tag),
        .wb_index   (wb_index),
        .wb_ack     (wb_ack),
        .flush_busy (flush_busy),
        .flush_done (flush_done)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({tag_rptr, tag_uwr, tag_uptr, tag_udata, tag_flush,
                    wb_req, wb_tag, wb_index, flush_busy, flush_done});
    endfunction

    // One complete walk from a negedge with the DUT idle. hold_ack keeps
    // wb_ack high throughout; noise toggles flush_req while busy and wb_ack
    // outside writebacks; fixed_lat > 0 forces every writeback latency.
    task automatic run_walk(input string name, input bit hold_ack, input bit noise,
                            input int fixed_lat);
        logic [WD-1:0] e;
        logic [WD-1:0] upd;
        logic [WD-1:0] exp_mem [DP];
        int            lat [$];
        int            exp_wb_idx [$];
        int            exp_wb_tag [$];
        int            exp_up [$];
        int            obs_wb_idx [$];
        int            obs_wb_tag [$];
        int            obs_wb_dur [$];
        int            obs_up [$];
        int            exp_cycles, cyc, done_cnt, done_cyc, flush_cnt, busy_cnt;
        int            wb_run, unstable, post, l, need;
        logic [AW-1:0] cur_idx;
        logic [WD-3:0] cur_tag;

        // Reference: cost of each entry and its side effects.
        exp_cycles = 0;
        for (int i = 0; i < DP; i++) exp_mem[i] = mem[i];
        if (!tag_empty) begin
            for (int i = 0; i < DP; i++) begin
                e = mem[i];
                if (e[WD-1] && e[WD-2]) begin
                    l = hold_ack ? 1 : ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4)));
                    lat.push_back(l);
                    exp_wb_idx.push_back(i);
                    exp_wb_tag.push_back(int'(e[WD-3:0]));
                    upd = INVAL ? '0 : {2'b10, e[WD-3:0]};
                    exp_up.push_back(i * 256 + int'(upd));
                    exp_mem[i] = upd;
                    exp_cycles += 2 + l;
                end else if (e[WD-1] && INVAL) begin
                    exp_up.push_back(i * 256);
                    exp_mem[i] = '0;
                    exp_cycles += 2;
                end else begin
                    exp_cycles += 1;
                end
            end
        end

        flush_req = 1'b1;
        wb_ack    = hold_ack;
        cyc = 0; done_cnt = 0; done_cyc = 0; flush_cnt = 0; busy_cnt = 0;
        wb_run = 0; unstable = 0; post = -1; cur_idx = '0; cur_tag = '0;

        while (cyc < 500 && post != 0) begin
            @(negedge clk);
            cyc++;
            if (post > 0) post--;
            if (flush_busy) busy_cnt++;
            if (flush_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    post = 3;
                end
            end
            if (tag_flush) flush_cnt++;
            if (tag_uwr) begin
                obs_up.push_back(int'(tag_uptr) * 256 + int'(tag_udata));
                mem[tag_uptr] = tag_udata;
            end
            if (wb_req) begin
                if (wb_run == 0) begin
                    cur_idx = wb_index;
                    cur_tag = wb_tag;
                end else if (wb_index !== cur_idx || wb_tag !== cur_tag) begin
                    unstable++;
                end
                wb_run++;
            end
            need = (obs_wb_idx.size() < lat.size()) ? lat[obs_wb_idx.size()] : 1;
            if (wb_req && wb_run >= need) begin
                wb_ack = 1'b1;
                obs_wb_idx.push_back(int'(cur_idx));
                obs_wb_tag.push_back(int'(cur_tag));
                obs_wb_dur.push_back(wb_run);
                wb_run = 0;
            end else if (hold_ack) begin
                wb_ack = 1'b1;
            end else begin
                wb_ack = (noise && !wb_req) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            flush_req = (noise && done_cnt == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        flush_req = 1'b0;
        wb_ack    = 1'b0;

        check({name, " done_count"}, 32'(done_cnt), 32'd1);
        check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_cycles + 1));
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_cycles + 1));
        check({name, " tag_flush_count"}, 32'(flush_cnt), INVAL ? 32'd1 : 32'd0);
        check({name, " wb_count"}, 32'(obs_wb_idx.size()), 32'(exp_wb_idx.size()));
        check({name, " wb_stable"}, 32'(unstable), 32'd0);
        for (int k = 0; k < obs_wb_idx.size() && k < exp_wb_idx.size(); k++) begin
            check($sformatf("%s wb%0d_index", name, k), 32'(obs_wb_idx[k]), 32'(exp_wb_idx[k]));
            check($sformatf("%s wb%0d_tag", name, k), 32'(obs_wb_tag[k]), 32'(exp_wb_tag[k]));
            check($sformatf("%s wb%0d_len", name, k), 32'(obs_wb_dur[k]), 32'(lat[k]));
        end
        check({name, " upd_count"}, 32'(obs_up.size()), 32'(exp_up.size()));
        for (int k = 0; k < obs_up.size() && k < exp_up.size(); k++)
            check($sformatf("%s upd%0d", name, k), 32'(obs_up[k]), 32'(exp_up[k]));
        for (int i = 0; i < DP; i++)
            check($sformatf("%s mem%0d", name, i), 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    initial begin : main
        int k;

        // Reset state
        for (int i = 0; i < DP; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("reset outputs", all_outputs(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle after reset", all_outputs(), 32'd0);

        // Empty FIFO: straight to done
        tag_empty = 1'b1;
        run_walk("empty", 1'b0, 1'b0, 0);
        tag_empty = 1'b0;

        // All valid and clean
        for (int i = 0; i < DP; i++) mem[i] = {2'b10, 6'($urandom)};
        run_walk("clean", 1'b0, 1'b0, 0);

        // Single dirty line at index 2, ack latency 3
        mem[0] = 8'h00; mem[1] = 8'h15; mem[2] = 8'hEA; mem[3] = 8'h40;
        run_walk("dirty2", 1'b0, 1'b0, 3);
        check("dirty2 cleaned entry", 32'(mem[2]), INVAL ? 32'h00 : 32'hAA);

        // All dirty with ack held high
        for (int i = 0; i < DP; i++) mem[i] = {2'b11, 6'($urandom)};
        run_walk("alldirty", 1'b1, 1'b0, 0);

        // Reset during the writeback of entry 1
        for (int i = 0; i < DP; i++) mem[i] = {2'b11, 6'($urandom)};
        flush_req = 1'b1;
        k = 0;
        while (k < 50 && !(wb_req && wb_index == 2'd1)) begin
            @(negedge clk);
            flush_req = 1'b0;
            if (tag_uwr) mem[tag_uptr] = tag_udata;
            wb_ack = wb_req && (wb_index == 2'd0);
            k++;
        end
        wb_ack = 1'b0;
        check("rst reached wb1", 32'(wb_req && wb_index == 2'd1), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("rst outputs mid-walk", all_outputs(), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        repeat (4) begin
            @(negedge clk);
            if (flush_done || flush_busy || wb_req || tag_uwr || tag_flush) k++;
        end
        check("rst quiet after release", 32'(k), 32'd0);
        run_walk("after_rst", 1'b0, 1'b0, 0);

        // Randomized walks with spurious flush_req / wb_ack
        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < DP; i++) mem[i] = 8'($urandom);
            tag_empty = ($urandom_range(0, 7) == 0);
            run_walk($sformatf("rand%0d", w), ($urandom_range(0, 5) == 0), 1'b1, 0);
        end
        tag_empty = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
